qspi_rx_deser: RTL and testbench

QSPI_RX_DESER -- requirements
Module: qspi_rx_deser

---
 rtl/qspi_pkg.sv | 18 +
 rtl/qspi_lane_sel.sv | 35 +++
 rtl/qspi_rx_deser.sv | 121 ++++++++++++
 tb/tb_qspi_rx_deser.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// QSPI receive deserializer shared types.
// Lane-mode encoding and FSM state encoding.
package qspi_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'b00,
    MODE_DUAL   = 2'b01,
    MODE_QUAD   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_HOLD  = 2'b10
  } state_e;

endpackage

// File: rtl/qspi_lane_sel.sv
// Maps the lane mode to lanes-per-sample and
// the right-aligned lane bits taken from sd_i.
module qspi_lane_sel
  import qspi_pkg::*;
(
  input  logic [1:0] mode_i,
  input  logic [3:0] sd_i,
  output logic [2:0] k_o,
  output logic [3:0] lanes_o
);

  mode_e mode;
  assign mode = mode_e'(mode_i);

  // Reserved mode falls back to single-lane on IO1
  always_comb begin
    k_o     = 3'd1;
    lanes_o = {3'b000, sd_i[1]};
    unique case (1'b1)
      (mode == MODE_DUAL): begin
        k_o     = 3'd2;
        lanes_o = {2'b00, sd_i[1:0]};
      end
      (mode == MODE_QUAD): begin
        k_o     = 3'd4;
        lanes_o = sd_i;
      end
      default: begin
        k_o     = 3'd1;
        lanes_o = {3'b000, sd_i[1]};
      end
    endcase
  end

endmodule

// File: rtl/qspi_rx_deser.sv
// QSPI receive deserializer: assembles 1/2/4-lane
// samples into a word and holds it for a handshake.
module qspi_rx_deser
  import qspi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = $clog2(DATA_W/8) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic              msb_first_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              sample_i,
  input  logic [3:0]        sd_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              overrun_o
);

  localparam int CNT_W = $clog2(DATA_W + 4) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);

  state_e            state_q, state_d;
  logic [1:0]        mode_q;
  logic              msb_q;
  logic [LEN_W-1:0]  len_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_bits, nbits;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] mask, lanes_w;
  logic              ovr_q;
  logic [2:0]        k;
  logic [3:0]        lanes;
  logic              last;

  qspi_lane_sel u_lane_sel (
    .mode_i  (mode_q),
    .sd_i    (sd_i),
    .k_o     (k),
    .lanes_o (lanes)
  );

  // Word length in bits; 0 or oversize means full width
  assign len_bits = CNT_W'({len_q, 3'b000});
  assign nbits = ((len_q == '0) || (len_bits > FULL))
               ? FULL : len_bits;

  // Out-of-range shift yields zero, so full width gives all ones
  assign mask    = ~({DATA_W{1'b1}} << nbits);
  assign lanes_w = DATA_W'(lanes);
  assign cnt_d   = cnt_q + CNT_W'(k);
  assign last    = (cnt_d >= nbits);

  // Next word value for one sample, bits above length forced to 0
  always_comb begin
    data_d = data_q;
    if (msb_q) begin
      data_d = ((data_q << k) | lanes_w) & mask;
    end else begin
      data_d = (data_q | (lanes_w << cnt_q)) & mask;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_SHIFT;
      ST_SHIFT: if (sample_i && last) state_d = ST_HOLD;
      ST_HOLD:  if (ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    valid_o = (state_q == ST_HOLD);
    busy_o  = (state_q == ST_SHIFT) || (state_q == ST_HOLD);
  end

  // Config latch, shift register, counter and overrun flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q <= '0;
      msb_q  <= 1'b0;
      len_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      ovr_q <= (state_q == ST_HOLD) && sample_i;
      if ((state_q == ST_IDLE) && start_i) begin
        mode_q <= mode_i;
        msb_q  <= msb_first_i;
        len_q  <= len_i;
        cnt_q  <= '0;
        data_q <= '0;
      end else if ((state_q == ST_SHIFT) && sample_i) begin
        cnt_q  <= cnt_d;
        data_q <= data_d;
      end
    end
  end

  assign data_o    = data_q;
  assign overrun_o = ovr_q;

endmodule

// File: tb/tb_qspi_rx_deser.sv
// Directed bench for qspi_rx_deser.
// Inputs change on negedge, outputs checked on negedge.
module tb_qspi_rx_deser;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  mode_i;
  logic        msb_first_i;
  logic [2:0]  len_i;
  logic        sample_i;
  logic [3:0]  sd_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic        busy_o;
  logic        overrun_o;

  int n_cmp = 0;
  int n_bad = 0;

  qspi_rx_deser dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .mode_i      (mode_i),
    .msb_first_i (msb_first_i),
    .len_i       (len_i),
    .sample_i    (sample_i),
    .sd_i        (sd_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic start_w(input logic [1:0] m,
                         input logic msb,
                         input logic [2:0] len);
    mode_i = m; msb_first_i = msb; len_i = len;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic samp(input logic [3:0] v);
    sd_i = v; sample_i = 1'b1;
    @(negedge clk_i);
    sample_i = 1'b0; sd_i = 4'h0;
  endtask

  task automatic accept();
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    n_cmp++;
    if ({data_o, valid_o, busy_o, overrun_o} !== 35'h0) begin
      n_bad++;
      $display("FAIL reset: data=%h v=%b b=%b o=%b want all 0",
               data_o, valid_o, busy_o, overrun_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_quad_msb();
    logic [3:0] nb [8] = '{4'hA, 4'hB, 4'hC, 4'hD,
                          4'h1, 4'h2, 4'h3, 4'h4};
    start_w(2'b10, 1'b1, 3'd4);
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL quad_busy: got %b want 1", busy_o);
    end
    for (int i = 0; i < 7; i++) samp(nb[i]);
    n_cmp++;
    if (valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL quad_early_valid: got %b want 0", valid_o);
    end
    samp(nb[7]);
    n_cmp++;
    if (valid_o !== 1'b1 || data_o !== 32'hABCD1234) begin
      n_bad++;
      $display("FAIL quad_msb: v=%b data=%h want 1 abcd1234",
               valid_o, data_o);
    end
    accept();
    n_cmp++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL quad_release: v=%b b=%b want 0 0",
               valid_o, busy_o);
    end
  endtask

  task automatic test_single_lsb();
    start_w(2'b00, 1'b0, 3'd1);
    samp(4'b0010);
    for (int i = 0; i < 7; i++) samp(4'b1101);
    n_cmp++;
    if (valid_o !== 1'b1 || data_o !== 32'h00000001) begin
      n_bad++;
      $display("FAIL single_lsb: v=%b data=%h want 1 00000001",
               valid_o, data_o);
    end
    accept();
  endtask

  task automatic test_dual_msb();
    logic [3:0] pr [8] = '{4'd3, 4'd0, 4'd3, 4'd0,
                          4'd1, 4'd1, 4'd1, 4'd1};
    start_w(2'b01, 1'b1, 3'd2);
    for (int i = 0; i < 8; i++) samp(pr[i] | 4'hC);
    n_cmp++;
    if (valid_o !== 1'b1 || data_o !== 32'h0000CC55) begin
      n_bad++;
      $display("FAIL dual_msb: v=%b data=%h want 1 0000cc55",
               valid_o, data_o);
    end
    accept();
  endtask

  task automatic test_quad_lsb_full();
    start_w(2'b10, 1'b0, 3'd0);
    for (int i = 1; i <= 8; i++) samp(4'(i));
    n_cmp++;
    if (valid_o !== 1'b1 || data_o !== 32'h87654321) begin
      n_bad++;
      $display("FAIL quad_lsb_len0: v=%b data=%h want 1 87654321",
               valid_o, data_o);
    end
    accept();
  endtask

  task automatic test_rsvd_mode();
    start_w(2'b11, 1'b1, 3'd1);
    for (int i = 0; i < 8; i++) samp(i[0] ? 4'b1101 : 4'b0010);
    n_cmp++;
    if (valid_o !== 1'b1 || data_o !== 32'h000000AA) begin
      n_bad++;
      $display("FAIL rsvd_mode: v=%b data=%h want 1 000000aa",
               valid_o, data_o);
    end
    accept();
  endtask

  task automatic test_hold_overrun();
    int ovr = 0;
    start_w(2'b10, 1'b1, 3'd1);
    samp(4'h5);
    samp(4'hA);
    for (int i = 0; i < 5; i++) begin
      sample_i = (i == 1 || i == 3);
      sd_i = 4'hF;
      @(negedge clk_i);
      sample_i = 1'b0;
      if (overrun_o === 1'b1) ovr++;
      n_cmp++;
      if (data_o !== 32'h0000005A || valid_o !== 1'b1) begin
        n_bad++;
        $display("FAIL hold_stable[%0d]: v=%b data=%h want 1 5a",
                 i, valid_o, data_o);
      end
    end
    @(negedge clk_i);
    if (overrun_o === 1'b1) ovr++;
    n_cmp++;
    if (ovr !== 2 || busy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_count: got %0d busy=%b want 2 1",
               ovr, busy_o);
    end
    ready_i = 1'b1;
    start_i = 1'b1;
    mode_i = 2'b00;
    @(negedge clk_i);
    ready_i = 1'b0;
    start_i = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL handshake_start: b=%b v=%b want 0 0",
               busy_o, valid_o);
    end
    @(negedge clk_i);
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL handshake_start_late: b=%b want 0", busy_o);
    end
  endtask

  task automatic test_reset_mid();
    start_w(2'b10, 1'b1, 3'd4);
    samp(4'h9);
    samp(4'h9);
    samp(4'h9);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    n_cmp++;
    if ({data_o, valid_o, busy_o, overrun_o} !== 35'h0) begin
      n_bad++;
      $display("FAIL reset_mid: data=%h v=%b b=%b o=%b want 0",
               data_o, valid_o, busy_o, overrun_o);
    end
    start_w(2'b10, 1'b1, 3'd4);
    for (int i = 1; i <= 8; i++) samp(4'(i));
    n_cmp++;
    if (valid_o !== 1'b1 || data_o !== 32'h12345678) begin
      n_bad++;
      $display("FAIL after_reset: v=%b data=%h want 1 12345678",
               valid_o, data_o);
    end
    accept();
  endtask

  task automatic test_start_ignored();
    sd_i = 4'hF; sample_i = 1'b1;
    start_w(2'b10, 1'b1, 3'd2);
    sample_i = 1'b0; sd_i = 4'h0;
    samp(4'hA);
    samp(4'hB);
    mode_i = 2'b00; msb_first_i = 1'b0; len_i = 3'd1;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    samp(4'hC);
    samp(4'hD);
    n_cmp++;
    if (valid_o !== 1'b1 || data_o !== 32'h0000ABCD) begin
      n_bad++;
      $display("FAIL start_in_shift: v=%b data=%h want 1 abcd",
               valid_o, data_o);
    end
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    n_cmp++;
    if (valid_o !== 1'b1 || data_o !== 32'h0000ABCD) begin
      n_bad++;
      $display("FAIL start_in_hold: v=%b data=%h want 1 abcd",
               valid_o, data_o);
    end
    accept();
  endtask

  task automatic test_idle_quiet();
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) samp(4'hF);
    ready_i = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b0 || overrun_o !== 1'b0 ||
        valid_o !== 1'b0 || data_o !== 32'h0000ABCD) begin
      n_bad++;
      $display("FAIL idle_sample: b=%b o=%b v=%b data=%h",
               busy_o, overrun_o, valid_o, data_o);
    end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; mode_i = 2'b00;
    msb_first_i = 1'b0; len_i = 3'd0; sample_i = 1'b0;
    sd_i = 4'h0; ready_i = 1'b0;
    test_reset();
    test_quad_msb();
    test_single_lsb();
    test_dual_msb();
    test_quad_lsb_full();
    test_rsvd_mode();
    test_hold_overrun();
    test_reset_mid();
    test_start_ignored();
    test_idle_quiet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
